// File: rtl/vec_add_coproc_if.sv
// vec_add_coproc_if: Wishbone slave bus bundle for the vector add coprocessor
interface vec_add_coproc_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/vec_add_coproc.sv
// vec_add_coproc: Wishbone-mapped vector adder computing one element per clock
module vec_add_coproc #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          VLEN      = 8,
    parameter int          ELEN      = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    vec_add_coproc_if.slave    bus,
    output logic               irq_o
);
    localparam logic [5:0] LV   = 6'(VLEN);
    localparam logic [4:0] VMAX = 5'(VLEN);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t          r_state;
    logic [ELEN-1:0] r_a [16];
    logic [ELEN-1:0] r_b [16];
    logic [ELEN-1:0] r_c [16];
    logic [4:0]      r_vl;
    logic [3:0]      r_idx;
    logic            r_done;
    logic            r_irq;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic [11:0]     w_off;
    logic [3:0]      w_eidx;
    logic            w_in;
    logic            w_hit;
    logic            w_wr;
    logic            w_busy;
    logic            w_is_ctrl;
    logic            w_is_vl;
    logic            w_is_a;
    logic            w_is_b;
    logic            w_is_c;
    logic            w_start;
    logic            w_last;
    logic [31:0]     w_rdata;
    logic            w_unused;
    assign w_off     = bus.wbs_adr_i[11:0];
    assign w_eidx    = w_off[5:2];
    assign w_in      = w_off[7:2] < LV;
    // the ~r_ack term gives the mandatory idle cycle after every ack
    assign w_hit     = bus.wbs_stb_i & bus.wbs_cyc_i & ~r_ack &
                       (bus.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_wr      = w_hit & bus.wbs_we_i;
    assign w_busy    = r_state == S_RUN;
    assign w_is_ctrl = w_off[11:2] == 10'd0;
    assign w_is_vl   = w_off[11:2] == 10'd1;
    assign w_is_a    = (w_off[11:8] == 4'd1) & w_in;
    assign w_is_b    = (w_off[11:8] == 4'd2) & w_in;
    assign w_is_c    = (w_off[11:8] == 4'd3) & w_in;
    assign w_start   = w_wr & w_is_ctrl & bus.wbs_sel_i[0] & bus.wbs_dat_i[0] & ~w_busy;
    assign w_last    = (r_vl == 5'd0) | ({1'b0, r_idx} == r_vl - 5'd1);
    assign w_unused  = &{1'b0, bus.wbs_adr_i[1:0]};
    assign w_rdata   = w_is_ctrl ? {29'd0, r_done, w_busy, 1'b0} :
                       w_is_vl   ? {27'd0, r_vl} :
                       w_is_a    ? r_a[w_eidx] :
                       w_is_b    ? r_b[w_eidx] :
                       w_is_c    ? r_c[w_eidx] : 32'd0;
    assign bus.wbs_ack_o = r_ack;
    assign bus.wbs_dat_o = r_dat;
    assign irq_o         = r_irq;
    // bus response and host-writable operand/length registers, frozen while busy
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_vl  <= VMAX;
            for (int i = 0; i < 16; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            r_ack <= w_hit;
            r_dat <= w_hit ? w_rdata : '0;
            if (w_wr && !w_busy) begin
                if (w_is_vl && bus.wbs_sel_i[0])
                    r_vl <= (bus.wbs_dat_i[4:0] > VMAX) ? VMAX : bus.wbs_dat_i[4:0];
                for (int k = 0; k < 4; k++) begin
                    if (w_is_a && bus.wbs_sel_i[k]) r_a[w_eidx][8*k +: 8] <= bus.wbs_dat_i[8*k +: 8];
                    if (w_is_b && bus.wbs_sel_i[k]) r_b[w_eidx][8*k +: 8] <= bus.wbs_dat_i[8*k +: 8];
                end
            end
        end
    end
    // compute sequencer: one C element per RUN cycle, then DONE and a one-cycle irq
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_irq   <= 1'b0;
            for (int i = 0; i < 16; i++) r_c[i] <= '0;
        end else begin
            r_irq <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_state <= S_RUN;
                    r_idx   <= '0;
                    r_done  <= 1'b0;
                end
            end else begin
                if ({1'b0, r_idx} < r_vl) r_c[r_idx] <= r_a[r_idx] + r_b[r_idx];
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_irq   <= 1'b1;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_add_coproc.sv
// tb_vec_add_coproc: directed plus randomized checks of the vector add coprocessor
module tb_vec_add_coproc;
    localparam logic [31:0] BA = 32'h3000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    vec_add_coproc_if bus_if ();
    vec_add_coproc dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_if.slave), .irq_o(irq));
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int ecount = 0;
    int irq_cnt = 0;
    int irq_edge = 0;
    int ack_edge = 0;
    logic [31:0] ma [8];
    logic [31:0] mb [8];
    logic [31:0] mc [8];
    int mvl;
    always @(posedge clk) ecount <= ecount + 1;
    always @(negedge clk) if (irq) begin irq_cnt++; irq_edge = ecount; end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        @(negedge clk);
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_we_i  = we;
        bus_if.wbs_adr_i = adr;
        bus_if.wbs_dat_i = dat;
        bus_if.wbs_sel_i = sel;
        acked = 1'b0;
        rd = '0;
        for (int k = 0; k < 4 && !acked; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.wbs_ack_o) begin
                acked = 1'b1;
                rd = bus_if.wbs_dat_o;
                ack_edge = ecount;
            end
        end
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
    endtask
    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] dat);
        logic [31:0] rd;
        logic a;
        bus_xfer(1'b1, BA + off, dat, 4'hF, rd, a);
        check({tag, "_ack"}, 32'(a), 32'd1);
    endtask
    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic a;
        bus_xfer(1'b0, BA + off, 32'd0, 4'hF, rd, a);
        check({tag, "_ack"}, 32'(a), 32'd1);
        check(tag, rd, exp);
    endtask
    task automatic set_ab(input int i, input logic [31:0] a, input logic [31:0] b);
        wr("wrA", 32'('h100 + 4 * i), a);
        wr("wrB", 32'('h200 + 4 * i), b);
        ma[i] = a;
        mb[i] = b;
    endtask
    task automatic rand_ab();
        for (int i = 0; i < 8; i++) set_ab(i, $urandom, $urandom);
    endtask
    task automatic set_vl(input int v);
        wr("wrVL", 32'h4, 32'(v));
        mvl = ((v & 31) > 8) ? 8 : (v & 31);
    endtask
    task automatic check_c(input string tag);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("%s_C%0d", tag, i), 32'('h300 + 4 * i), mc[i]);
    endtask
    task automatic model_run();
        for (int i = 0; i < mvl; i++) mc[i] = ma[i] + mb[i];
    endtask
    task automatic run(input string tag);
        int n0;
        int s;
        n0 = irq_cnt;
        wr({tag, "_start"}, 32'h0, 32'h1);
        s = ack_edge;
        for (int k = 0; k < 40 && irq_cnt == n0; k++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_irqs"}, 32'(irq_cnt - n0), 32'd1);
        check({tag, "_lat"}, 32'(irq_edge - s), 32'((mvl == 0) ? 1 : mvl));
        model_run();
        rd_chk({tag, "_ctrl"}, 32'h0, 32'h4);
        check_c(tag);
    endtask
    initial begin
        logic [31:0] rd;
        logic a;
        int n0;
        int s;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
        bus_if.wbs_sel_i = 4'h0;
        bus_if.wbs_adr_i = '0;
        bus_if.wbs_dat_i = '0;
        for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; mc[i] = '0; end
        mvl = 8;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        // reset: hit an ack with nonzero data, then assert reset between edges
        @(negedge clk);
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_adr_i = BA + 32'h4;
        bus_if.wbs_sel_i = 4'hF;
        @(posedge clk);
        #1;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        check("pre_rst_ack", 32'(bus_if.wbs_ack_o), 32'd1);
        check("pre_rst_dat", bus_if.wbs_dat_o, 32'd8);
        rst = 1'b1;
        #1;
        check("rst_ack", 32'(bus_if.wbs_ack_o), 32'd0);
        check("rst_dat", bus_if.wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_vl", 32'h4, 32'd8);
        check_c("rst");
        // full-length add
        for (int i = 0; i < 8; i++) set_ab(i, 32'(i + 1), 32'(16 * (i + 1)));
        set_vl(8);
        run("full");
        // carry wraps modulo 2^32
        set_ab(0, 32'hFFFF_FFFF, 32'h2);
        set_vl(1);
        run("wrap");
        // C is read-only: write acked, contents unchanged
        wr("c_wr", 32'h308, 32'h1234_5678);
        rd_chk("c_wr_rb", 32'h308, mc[2]);
        // partial length keeps upper results, then VL clamp
        rand_ab();
        set_vl(3);
        run("part");
        set_vl(20);
        rd_chk("clamp", 32'h4, 32'd8);
        // randomized lengths and data, first one VL = 0
        for (int it = 0; it < 3; it++) begin
            rand_ab();
            set_vl((it == 0) ? 0 : int'($urandom_range(0, 31)));
            run($sformatf("rnd%0d", it));
        end
        // writes during RUN are acked but ignored; restart ignored
        rand_ab();
        set_vl(8);
        n0 = irq_cnt;
        wr("busy_start", 32'h0, 32'h1);
        s = ack_edge;
        wr("busy_a5", 32'h114, 32'h0000_DEAD);
        wr("busy_restart", 32'h0, 32'h1);
        rd_chk("busy_ctrl", 32'h0, 32'h2);
        rd_chk("busy_a5_rb", 32'h114, ma[5]);
        for (int k = 0; k < 40 && irq_cnt == n0; k++) @(posedge clk);
        repeat (14) @(posedge clk);
        #1;
        check("busy_irqs", 32'(irq_cnt - n0), 32'd1);
        check("busy_lat", 32'(irq_edge - s), 32'd8);
        model_run();
        rd_chk("busy_done", 32'h0, 32'h4);
        check_c("busy");
        // byte lanes on A
        set_ab(0, 32'h0, mb[0]);
        bus_xfer(1'b1, BA + 32'h100, 32'hAABB_CCDD, 4'b0010, rd, a);
        check("sel_ack", 32'(a), 32'd1);
        rd_chk("sel_rb", 32'h100, 32'h0000_CC00);
        // unmapped offset inside window, and outside window
        rd_chk("hole", 32'h400, 32'h0);
        bus_xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, rd, a);
        check("oow_ack", 32'(a), 32'd0);
        // reset mid-RUN
        wr("mid_start", 32'h0, 32'h1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_ack", 32'(bus_if.wbs_ack_o), 32'd0);
        check("mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin ma[i] = '0; mb[i] = '0; mc[i] = '0; end
        mvl = 8;
        rd_chk("mid_ctrl", 32'h0, 32'h0);
        rd_chk("mid_vl", 32'h4, 32'd8);
        rd_chk("mid_a3", 32'h10C, ma[3]);
        check_c("mid");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
